ternary_to_binary_seq: RTL and testbench

- Sequential decoder from balanced-ternary to two's-complement binary. It is the reverse direction of the ternary_adder datapath, which is driven by binary-to-ternary encoding.
- Accepts one WIDTH-trit word plus one extension trit (the adder's cout, weight 3^WIDTH). Converts MSB-first with Horner's rule, one trit per clock.
- Sits on ternary_adder / ALU result paths where binary consumers (debug bus, scoreboards, host registers) need the signed value.

---
 rtl/ternary_to_binary_seq.sv | 171 +++++++++++++++++
 tb/tb_ternary_to_binary_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_to_binary_seq.sv
// Balanced-ternary to two's-complement decoder, one trit per clock.
//
// Converts a WIDTH-trit word plus one extension trit (weight 3^WIDTH, typically the
// ternary adder's carry out) into a signed BIN_W-bit value using Horner's rule,
// starting with the extension trit and finishing with din[0].
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous, active-high reset
//   in_valid  din/din_ext valid
//   in_ready  block can accept a word (IDLE and not in reset)
//   din       value trits, index 0 = LSB (weight 3^0)
//   din_ext   extension trit, weight 3^WIDTH
//   out_valid dout/err valid
//   out_ready consumer accepts the result
//   dout      signed result
//   err       at least one trit of the word carried an undefined code

package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;

endpackage

module ternary_to_binary_seq
  import ternary_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BIN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  trit_t [WIDTH-1:0]       din,
  input  trit_t                   din_ext,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        dout,
  output logic                    err
);

  // Bits needed for the largest magnitude (3^(WIDTH+1)-1)/2, plus a sign bit.
  function automatic int min_bin_w(input int unsigned w);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i <= w; i++) begin
      p = p * 64'd3;
    end
    return 1 + $clog2((p - 64'd1) / 64'd2 + 64'd1);
  endfunction

  if (int'(BIN_W) < min_bin_w(WIDTH)) begin : g_bin_w_check
    $error("BIN_W too small for WIDTH value trits plus extension trit");
  end

  localparam int unsigned CntW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  trit_t [WIDTH:0]           sr_q, sr_d;
  logic signed [BIN_W-1:0]   acc_q, acc_d;
  logic                      err_acc_q, err_acc_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [BIN_W-1:0]          dout_q, dout_d;
  logic                      err_q, err_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [BIN_W-1:0]   trit_val;
  logic                      trit_bad;
  logic signed [BIN_W-1:0]   acc_step;

  // Decode the trit currently at the top of the shift register.
  always_comb begin
    trit_val = '0;
    trit_bad = 1'b0;
    unique case (sr_q[WIDTH])
      T_ZERO:    trit_val = '0;
      T_POS_ONE: trit_val = BIN_W'(1);
      T_NEG_ONE: trit_val = {BIN_W{1'b1}};
      default:   trit_bad = 1'b1;
    endcase
  end

  // acc*3 + trit, with the multiply done as a shift and add.
  assign acc_step = (acc_q <<< 1) + acc_q + trit_val;

  assign in_ready = (state_q == StIdle) && !rst;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    err_acc_d   = err_acc_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          sr_d      = {din_ext, din};
          acc_d     = '0;
          err_acc_d = 1'b0;
          cnt_d     = CntW'(WIDTH);
          state_d   = StConv;
        end
      end
      StConv: begin
        acc_d     = acc_step;
        sr_d      = {sr_q[WIDTH-1:0], T_ZERO};
        err_acc_d = err_acc_q | trit_bad;
        cnt_d     = cnt_q - 1'b1;
        // Counter reaches zero on the step that consumes din[0].
        if (cnt_q == '0) begin
          cnt_d       = '0;
          dout_d      = acc_step;
          err_d       = err_acc_q | trit_bad;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      acc_q       <= '0;
      err_acc_q   <= 1'b0;
      cnt_q       <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      err_acc_q   <= err_acc_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ternary_to_binary_seq.sv
// Self-checking bench for ternary_to_binary_seq: directed words, scoreboard of
// expected results computed from a positional-sum model, latency, back-pressure,
// invalid-code and mid-conversion reset checks.

module tb_ternary_to_binary_seq;
  import ternary_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned BW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  trit_t [W-1:0]     din;
  trit_t             din_ext;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     dout;
  logic              err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [BW-1:0] d;
    logic          e;
  } exp_t;

  exp_t sb[$];

  trit_t [W-1:0] d;

  always #5 clk = ~clk;

  ternary_to_binary_seq #(
    .WIDTH(W),
    .BIN_W(BW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .din_ext  (din_ext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .err      (err)
  );

  // Positional sum: sum(val(trit_i) * 3^i), extension at weight 3^W.
  function automatic logic [BW-1:0] model(input trit_t [W-1:0] dv, input trit_t ev,
                                          output logic er);
    int acc;
    int pw;
    trit_t t;
    acc = 0;
    pw  = 1;
    er  = 1'b0;
    for (int i = 0; i <= int'(W); i++) begin
      t = (i == int'(W)) ? ev : dv[i];
      if (t == T_POS_ONE)      acc = acc + pw;
      else if (t == T_NEG_ONE) acc = acc - pw;
      else if (t != T_ZERO)    er = 1'b1;
      pw = pw * 3;
    end
    return BW'(acc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, push its expected result, and wait for out_valid.
  task automatic send(input trit_t [W-1:0] dv, input trit_t ev, input string tag);
    logic          er;
    logic [BW-1:0] v;
    int            n;
    bit            ready_seen;
    v        = model(dv, ev, er);
    din      = dv;
    din_ext  = ev;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    sb.push_back('{d: v, e: er});
    n = 0;
    ready_seen = 1'b0;
    while (!out_valid && n < 30) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    check({tag, "_ready_conv"}, 32'(ready_seen), 32'd0);
  endtask

  // Compare the presented result against the scoreboard; out_ready must be high.
  task automatic collect(input string tag);
    exp_t x;
    x = '0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) x = sb.pop_front();
    check({tag, "_dout"}, 32'(dout), 32'(x.d));
    check({tag, "_err"}, 32'(err), 32'(x.e));
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    din_ext   = T_ZERO;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // All-zero word.
    d = '0;
    send(d, T_ZERO, "zero");
    collect("zero");

    // 27 - 9 - 3 = 15.
    d = '0;
    d[3] = T_POS_ONE;
    d[2] = T_NEG_ONE;
    d[1] = T_NEG_ONE;
    send(d, T_ZERO, "p15");
    check("p15_model", 32'(sb[0].d), 32'h000F);
    collect("p15");

    // -243 + 81 + 9 + 3 = -150.
    d = '0;
    d[5] = T_NEG_ONE;
    d[4] = T_POS_ONE;
    d[2] = T_POS_ONE;
    d[1] = T_POS_ONE;
    send(d, T_ZERO, "m150");
    check("m150_model", 32'(sb[0].d), 32'hFF6A);
    collect("m150");

    // Largest positive value including the extension trit.
    for (int i = 0; i < int'(W); i++) d[i] = T_POS_ONE;
    send(d, T_POS_ONE, "max");
    check("max_model", 32'(sb[0].d), 32'h2671);
    collect("max");

    // Extension trit alone, negative.
    d = '0;
    send(d, T_NEG_ONE, "ext_neg");
    check("ext_neg_model", 32'(sb[0].d), 32'hE65F);
    collect("ext_neg");

    // Back-pressure: hold DONE while in_valid/din wiggle.
    out_ready = 1'b0;
    d = '0;
    d[2] = T_POS_ONE;
    d[1] = T_POS_ONE;
    d[0] = T_POS_ONE;
    send(d, T_ZERO, "bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_dout", 32'(dout), 32'(sb[0].d));
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      in_valid = i[0];
      din      = W * 2'($urandom) == 0 ? '0 : (2 * W)'($urandom);
      din_ext  = T_POS_ONE;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    collect("bp");
    d = '0;
    d[0] = T_POS_ONE;
    send(d, T_ZERO, "one");
    check("one_model", 32'(sb[0].d), 32'h0001);
    collect("one");

    // Undefined code on din[3].
    d = '0;
    d[3] = trit_t'(2'b11);
    d[0] = T_POS_ONE;
    send(d, T_ZERO, "inv");
    check("inv_model_err", 32'(sb[0].e), 32'd1);
    collect("inv");

    // Reset at CONV step 4 discards the word.
    for (int i = 0; i < int'(W); i++) d[i] = T_POS_ONE;
    din      = d;
    din_ext  = T_POS_ONE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mid_rst_no_output", 32'(out_valid), 32'd0);
    end

    // -9 + 3 + 1 = -5.
    d = '0;
    d[2] = T_NEG_ONE;
    d[1] = T_POS_ONE;
    d[0] = T_POS_ONE;
    send(d, T_ZERO, "m5");
    check("m5_model", 32'(sb[0].d), 32'hFFFB);
    collect("m5");

    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
